// File: rtl/conv_seq_pkg.sv
// Shared opcodes, state encoding and default sizes for the convolution sequencer.
// Optional watchdog build macro: CONV_SEQ_WDOG_EN.
package conv_seq_pkg;

  localparam int NB_IMAGE_DEF    = 10;
  localparam int SOP_CYCLES_DEF  = 4;
  localparam int WDOG_CYCLES_DEF = 1024;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_READ  = 3'd3;
  localparam logic [2:0] OP_ABORT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SOP,
    ST_WAIT_EOP,
    ST_READ
  } state_t;

  function automatic logic is_reserved(input logic [2:0] op);
    return (op == 3'd4) || (op == 3'd5) || (op == 3'd6);
  endfunction

endpackage

// File: rtl/conv_seq_wdog.sv
// WAIT_EOP watchdog: counts cycles while enabled, flags expiry on the last one.
// Only instantiated when CONV_SEQ_WDOG_EN is defined.
module conv_seq_wdog
  import conv_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(WDOG_CYCLES) + 1;

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || !en) begin
      cnt_reg <= '0;
    end else if (!expire) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = en && (cnt_reg == CW'(WDOG_CYCLES - 1));

endmodule

// File: rtl/conv_sequencer.sv
// Host-command sequencer for the convolution FSM: LOAD/READ word transfers, RUN with SoP/EoP.
// Define CONV_SEQ_WDOG_EN to add a watchdog on WAIT_EOP that reports via o_error.
module conv_sequencer
  import conv_seq_pkg::*;
#(
  parameter int NB_IMAGE    = NB_IMAGE_DEF,
  parameter int SOP_CYCLES  = SOP_CYCLES_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic                i_CLK,
  input  logic                i_reset,
  input  logic                i_cmdValid,
  input  logic [2:0]          i_cmd,
  input  logic [NB_IMAGE-1:0] i_imgLength,
  input  logic                i_dataValid,
  input  logic                i_EoP,
  input  logic                i_changeBlock,
  output logic                o_load,
  output logic                o_valid,
  output logic                o_SoP,
  output logic [NB_IMAGE-1:0] o_imgLength,
  output logic [NB_IMAGE-1:0] o_blockCnt,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cmdErr,
  output logic                o_error
);

  localparam int SW = $clog2(SOP_CYCLES) + 1;

  state_t              state_reg, state_next;
  logic [NB_IMAGE-1:0] cnt_reg, cnt_next;
  logic [NB_IMAGE-1:0] len_reg, len_next;
  logic [NB_IMAGE-1:0] blk_reg, blk_next;
  logic [SW-1:0]       sop_cnt_reg, sop_cnt_next;
  logic                done_pend_reg, done_pend_next;
  logic                load_reg, load_next;
  logic                valid_reg, valid_next;
  logic                sop_reg, sop_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                cmderr_reg, cmderr_next;
  logic                error_next;
  logic                last_word;
  logic                abort;

  assign abort = i_cmdValid && (i_cmd == OP_ABORT);

`ifdef CONV_SEQ_WDOG_EN
  logic wdog_expire;
  logic error_reg;

  conv_seq_wdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (i_CLK),
    .srst  (i_reset),
    .en    (state_reg == ST_WAIT_EOP),
    .expire(wdog_expire)
  );

  always_ff @(posedge i_CLK) begin
    if (i_reset) error_reg <= 1'b0;
    else         error_reg <= error_next;
  end
  assign o_error = error_reg;
`else
  assign o_error = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    len_next       = len_reg;
    blk_next       = blk_reg;
    sop_cnt_next   = sop_cnt_reg;
    done_pend_next = 1'b0;
    valid_next     = 1'b0;
    done_next      = done_pend_reg;
    cmderr_next    = 1'b0;
    error_next     = 1'b0;
    last_word      = 1'b0;

    if ((state_reg == ST_SOP || state_reg == ST_WAIT_EOP) && i_changeBlock && (blk_reg != '1))
      blk_next = blk_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        if (i_cmdValid) begin
          case (i_cmd)
            OP_LOAD: begin
              len_next   = i_imgLength;
              cnt_next   = '0;
              state_next = ST_LOAD;
            end
            OP_READ: begin
              len_next   = i_imgLength;
              cnt_next   = '0;
              state_next = ST_READ;
            end
            OP_RUN: begin
              blk_next     = '0;
              sop_cnt_next = '0;
              state_next   = ST_SOP;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD, ST_READ: begin
        if (i_dataValid) begin
          valid_next = 1'b1;
          if (cnt_reg == len_reg) begin
            // o_done trails the final o_valid by one cycle
            state_next     = ST_IDLE;
            done_pend_next = 1'b1;
            last_word      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      ST_SOP: begin
        if (sop_cnt_reg == SW'(SOP_CYCLES - 1)) state_next = ST_WAIT_EOP;
        else                                   sop_cnt_next = sop_cnt_reg + 1'b1;
      end
      ST_WAIT_EOP: begin
        if (i_EoP) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end
`ifdef CONV_SEQ_WDOG_EN
        else if (wdog_expire) begin
          state_next = ST_IDLE;
          error_next = 1'b1;
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase

    if (i_cmdValid && (is_reserved(i_cmd) ||
        (state_reg != ST_IDLE && (i_cmd == OP_LOAD || i_cmd == OP_RUN || i_cmd == OP_READ))))
      cmderr_next = 1'b1;

    if (abort) begin
      state_next     = ST_IDLE;
      valid_next     = 1'b0;
      done_pend_next = 1'b0;
      done_next      = 1'b0;
      error_next     = 1'b0;
      last_word      = 1'b0;
    end

    // keep o_load up alongside the final word of a LOAD
    load_next = (state_next == ST_LOAD) || ((state_reg == ST_LOAD) && last_word);
    sop_next  = (state_next == ST_SOP);
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      len_reg       <= '0;
      blk_reg       <= '0;
      sop_cnt_reg   <= '0;
      done_pend_reg <= 1'b0;
      load_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      sop_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      cmderr_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      len_reg       <= len_next;
      blk_reg       <= blk_next;
      sop_cnt_reg   <= sop_cnt_next;
      done_pend_reg <= done_pend_next;
      load_reg      <= load_next;
      valid_reg     <= valid_next;
      sop_reg       <= sop_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
      cmderr_reg    <= cmderr_next;
    end
  end

  assign o_load      = load_reg;
  assign o_valid     = valid_reg;
  assign o_SoP       = sop_reg;
  assign o_imgLength = len_reg;
  assign o_blockCnt  = blk_reg;
  assign o_busy      = busy_reg;
  assign o_done      = done_reg;
  assign o_cmdErr    = cmderr_reg;

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed scoreboard bench for conv_sequencer: stimulus queues expected event cycles,
// a negedge monitor pops and compares them whenever o_valid/o_done/o_cmdErr/o_error fire.
module tb_conv_sequencer;

  localparam int NB = 10;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_cmdValid = 1'b0;
  logic [2:0]    i_cmd = 3'd0;
  logic [NB-1:0] i_imgLength = '0;
  logic          i_dataValid = 1'b0;
  logic          i_EoP = 1'b0;
  logic          i_changeBlock = 1'b0;
  logic          o_load, o_valid, o_SoP, o_busy, o_done, o_cmdErr, o_error;
  logic [NB-1:0] o_imgLength, o_blockCnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int q_valid[$];
  int q_done[$];
  int q_cmderr[$];
  int q_err[$];

  conv_sequencer #(
    .NB_IMAGE(NB),
    .SOP_CYCLES(4),
    .WDOG_CYCLES(16)
  ) dut (
    .i_CLK        (clk),
    .i_reset      (i_reset),
    .i_cmdValid   (i_cmdValid),
    .i_cmd        (i_cmd),
    .i_imgLength  (i_imgLength),
    .i_dataValid  (i_dataValid),
    .i_EoP        (i_EoP),
    .i_changeBlock(i_changeBlock),
    .o_load       (o_load),
    .o_valid      (o_valid),
    .o_SoP        (o_SoP),
    .o_imgLength  (o_imgLength),
    .o_blockCnt   (o_blockCnt),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_cmdErr     (o_cmdErr),
    .o_error      (o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got cycle %0d required below 20000", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("check %s = %0d ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic ev(input string name, input int e);
    checks++;
    if (e < 0) begin
      errors++;
      $display("FAIL %s: got unexpected event at cycle %0d required none", name, cyc);
    end else if (e != cyc) begin
      errors++;
      $display("FAIL %s: got event at cycle %0d required cycle %0d", name, cyc, e);
    end else begin
      $display("event %s at cycle %0d ok", name, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (o_valid)  ev("valid",  (q_valid.size()  == 0) ? -1 : q_valid.pop_front());
    if (o_done)   ev("done",   (q_done.size()   == 0) ? -1 : q_done.pop_front());
    if (o_cmdErr) ev("cmderr", (q_cmderr.size() == 0) ? -1 : q_cmderr.pop_front());
    if (o_error)  ev("error",  (q_err.size()    == 0) ? -1 : q_err.pop_front());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] op, input int len);
    i_cmdValid  = 1'b1;
    i_cmd       = op;
    i_imgLength = NB'(len);
    step();
    i_cmdValid  = 1'b0;
    i_cmd       = 3'd0;
  endtask

  task automatic word(input bit last);
    q_valid.push_back(cyc + 1);
    if (last) q_done.push_back(cyc + 2);
    i_dataValid = 1'b1;
    step();
    i_dataValid = 1'b0;
  endtask

  initial begin
    int n;
    int c;
    repeat (3) step();
    chk("reset_outputs", {o_load, o_valid, o_SoP, o_busy, o_done, o_cmdErr, o_error,
                          o_imgLength, o_blockCnt}, 0);
    i_reset = 1'b0;
    step();

    // stray strobes in IDLE, NOP, then a reserved opcode
    i_dataValid = 1'b1;
    i_EoP       = 1'b1;
    step();
    i_dataValid = 1'b0;
    i_EoP       = 1'b0;
    cmd(3'd0, 0);
    q_cmderr.push_back(cyc + 1);
    cmd(3'd5, 0);
    chk("reserved_idle", o_busy, 0);
    step();

    // LOAD 16 spaced words
    cmd(3'd1, 15);
    chk("load_len", o_imgLength, 15);
    chk("load_busy", o_busy, 1);
    for (int k = 0; k < 16; k++) begin
      word(k == 15);
      chk("load_high", o_load, 1);
      step();
    end
    chk("load_end_load", o_load, 0);
    chk("load_end_busy", o_busy, 0);

    // RUN rejected during LOAD, load finishes
    cmd(3'd1, 3);
    word(1'b0);
    step();
    q_cmderr.push_back(cyc + 1);
    cmd(3'd2, 0);
    chk("run_in_load_keep", o_load, 1);
    for (int k = 1; k < 4; k++) begin
      word(k == 3);
      step();
    end
    chk("run_in_load_busy", o_busy, 0);
    chk("run_in_load_sop", o_SoP, 0);

    // RUN: SoP width, block counting, EoP
    cmd(3'd2, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      n += int'(o_SoP);
      step();
    end
    chk("sop_cycles", n, 4);
    chk("run_busy", o_busy, 1);
    for (int i = 0; i < 3; i++) begin
      i_changeBlock = 1'b1;
      step();
      i_changeBlock = 1'b0;
      step();
    end
    chk("block_cnt", o_blockCnt, 3);
    q_done.push_back(cyc + 1);
    i_EoP = 1'b1;
    step();
    i_EoP = 1'b0;
    chk("eop_idle", o_busy, 0);
    step();

    // ABORT collides with 5th word of a length-9 LOAD
    cmd(3'd1, 9);
    for (int k = 0; k < 4; k++) begin
      word(1'b0);
      step();
    end
    i_dataValid = 1'b1;
    i_cmdValid  = 1'b1;
    i_cmd       = 3'd7;
    step();
    i_dataValid = 1'b0;
    i_cmdValid  = 1'b0;
    i_cmd       = 3'd0;
    chk("abort_busy", o_busy, 0);
    chk("abort_load", o_load, 0);
    repeat (3) step();

    // reset in the middle of a READ
    cmd(3'd3, 7);
    chk("read_load_low", o_load, 0);
    chk("read_busy", o_busy, 1);
    for (int k = 0; k < 3; k++) begin
      word(1'b0);
      step();
    end
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("midread_reset", {o_load, o_valid, o_SoP, o_busy, o_done, o_cmdErr, o_error,
                          o_imgLength, o_blockCnt}, 0);
    cmd(3'd3, 0);
    word(1'b1);
    step();
    chk("read0_idle", o_busy, 0);
    step();

`ifdef CONV_SEQ_WDOG_EN
    // RUN issued at cycle c: SoP c+1..c+4, WAIT_EOP c+5..c+20, o_error at c+21
    c = cyc;
    q_err.push_back(c + 21);
    cmd(3'd2, 0);
    repeat (30) step();
    chk("wdog_idle", o_busy, 0);
`else
    c = cyc;
    cmd(3'd2, 0);
    repeat (40) step();
    chk("nowdog_waiting", o_busy, 1);
    chk("nowdog_error", o_error, 0);
    cmd(3'd7, 0);
    chk("abort_wait_idle", o_busy, 0);
    chk("abort_wait_cycles", cyc - c, 42);
`endif

    repeat (4) step();
    chk("pending_valid", q_valid.size(), 0);
    chk("pending_done", q_done.size(), 0);
    chk("pending_cmderr", q_cmderr.size(), 0);
    chk("pending_error", q_err.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
